// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and shared-memory ports of the memory arbiter.
// The arbiter owns the memory command, so its side of the bundle is the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic                d_ready;
    logic [DATA_W-1:0]   d_rdata;

    logic                m_req;
    logic                m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_ready;
    logic [DATA_W-1:0]   m_rdata;

    modport master (
        input  i_req, i_addr, i_flush,
        output i_ready, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        output i_req, i_addr, i_flush,
        input  i_ready, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-outstanding memory bus.
// Data has priority; a starvation counter forces an instruction grant after STARVE_MAX data grants.
// Handshake: a requester holds req and its command stable until its ready pulses for one cycle;
// memory sees a registered m_req/command held until a one-cycle m_ready completes it.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus,
    output logic [1:0]    dbg_state
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t           state, state_nx;
    logic             gnt_i;
    logic             drop;
    logic [CNT_W-1:0] starve;
    logic             any_req;
    logic             pick_i;

    always_comb begin
        any_req = bus.i_req | bus.d_req;
        pick_i  = bus.i_req & (~bus.d_req | (starve == CNT_W'(STARVE_MAX)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = BUSY;
            BUSY:    if (bus.m_ready) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Ready pulses are combinational on RESP so a flush in that very cycle can still cancel the fetch.
    always_comb begin
        bus.i_ready = (state == RESP) & gnt_i & ~drop & ~bus.i_flush;
        bus.d_ready = (state == RESP) & ~gnt_i;
        dbg_state   = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_wstrb <= '0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
            gnt_i       <= 1'b0;
            drop        <= 1'b0;
            starve      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (!bus.i_req) starve <= '0;
                    if (any_req) begin
                        bus.m_req <= 1'b1;
                        gnt_i     <= pick_i;
                        if (pick_i) begin
                            bus.m_we    <= 1'b0;
                            bus.m_addr  <= bus.i_addr;
                            bus.m_wdata <= '0;
                            bus.m_wstrb <= '0;
                            starve      <= '0;
                            drop        <= bus.i_flush;
                        end else begin
                            bus.m_we    <= bus.d_we;
                            bus.m_addr  <= bus.d_addr;
                            bus.m_wdata <= bus.d_wdata;
                            bus.m_wstrb <= bus.d_wstrb;
                            if (bus.i_req && starve != CNT_W'(STARVE_MAX))
                                starve <= starve + CNT_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (bus.i_flush && gnt_i) drop <= 1'b1;
                    if (bus.m_ready) begin
                        bus.m_req <= 1'b0;
                        if (gnt_i) bus.i_rdata <= bus.m_rdata;
                        else       bus.d_rdata <= bus.m_rdata;
                    end
                end
                RESP:    drop <= 1'b0;
                default: drop <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each task drives one scenario and checks its own expectations.
module tb_mem_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int passed = 0;
    int total  = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; returns at the falling edge where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory driver: wait (bounded) for m_req, capture the command, pulse m_ready after extra cycles.
    // Returns at the falling edge of the RESP cycle.
    task automatic mem_serve(input int extra, input logic [31:0] rd, output bit ok,
                             output logic we, output logic [31:0] addr,
                             output logic [31:0] wd, output logic [3:0] strb);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.m_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        we = bus.m_we; addr = bus.m_addr; wd = bus.m_wdata; strb = bus.m_wstrb;
        if (ok) begin
            repeat (extra) tick();
            bus.m_ready = 1'b1;
            bus.m_rdata = rd;
            tick();
            bus.m_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req = 0; bus.i_addr = 0; bus.i_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
        bus.m_ready = 0; bus.m_rdata = 0;
        tick(); tick();
        total++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d exp 0", dbg_state); else passed++;
        total++; if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== 70'd0)
            $display("FAIL rst_mcmd: got req=%b addr=%h exp all zero", bus.m_req, bus.m_addr); else passed++;
        total++; if ({bus.i_ready, bus.d_ready, bus.i_rdata, bus.d_rdata} !== 66'd0)
            $display("FAIL rst_resp: got ir=%b dr=%b exp all zero", bus.i_ready, bus.d_ready); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        bus.i_req = 1; bus.i_addr = 32'h100;
        tick();
        total++; if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h100 || bus.m_we !== 1'b0)
            $display("FAIL fetch_cmd: got req=%b addr=%h we=%b exp 1/100/0", bus.m_req, bus.m_addr, bus.m_we); else passed++;
        bus.m_ready = 1; bus.m_rdata = 32'h13;
        tick();
        bus.m_ready = 0;
        total++; if (bus.i_ready !== 1'b1 || bus.i_rdata !== 32'h13)
            $display("FAIL fetch_resp: got ir=%b rdata=%h exp 1/00000013", bus.i_ready, bus.i_rdata); else passed++;
        total++; if (bus.m_req !== 1'b0) $display("FAIL fetch_mreq_drop: got %b exp 0", bus.m_req); else passed++;
        bus.i_req = 0;
        tick();
        total++; if (bus.i_ready !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL fetch_pulse_len: got ir=%b state=%0d exp 0/0", bus.i_ready, dbg_state); else passed++;
    endtask

    task automatic test_priority();
        bit ok; logic we; logic [31:0] a, wd; logic [3:0] s;
        bus.i_req = 1; bus.i_addr = 32'h104;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'hF;
        mem_serve(0, 32'h0, ok, we, a, wd, s);
        total++; if (!ok || we !== 1'b1 || a !== 32'h200 || wd !== 32'hDEADBEEF || s !== 4'hF)
            $display("FAIL prio_data_first: got ok=%b we=%b addr=%h wd=%h strb=%h exp 1/1/200/deadbeef/f", ok, we, a, wd, s); else passed++;
        total++; if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0)
            $display("FAIL prio_d_ready: got dr=%b ir=%b exp 1/0", bus.d_ready, bus.i_ready); else passed++;
        bus.d_req = 0; bus.d_we = 0;
        mem_serve(1, 32'h00A00093, ok, we, a, wd, s);
        total++; if (!ok || we !== 1'b0 || a !== 32'h104 || wd !== 32'h0 || s !== 4'h0)
            $display("FAIL prio_instr_next: got ok=%b we=%b addr=%h wd=%h strb=%h exp 1/0/104/0/0", ok, we, a, wd, s); else passed++;
        total++; if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.i_rdata !== 32'h00A00093)
            $display("FAIL prio_i_ready: got ir=%b dr=%b rdata=%h exp 1/0/00a00093", bus.i_ready, bus.d_ready, bus.i_rdata); else passed++;
        bus.i_req = 0;
        tick();
    endtask

    task automatic test_starve();
        bit ok; logic we; logic [31:0] a, wd; logic [3:0] s;
        int data_grants = 0;
        bus.i_req = 1; bus.i_addr = 32'h400;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
        for (int g = 0; g < 5; g++) begin
            mem_serve(0, 32'h0, ok, we, a, wd, s);
            if (ok && a === 32'h500) data_grants++;
        end
        total++; if (data_grants !== 4) $display("FAIL starve_data_grants: got %0d exp 4", data_grants); else passed++;
        total++; if (a !== 32'h400 || bus.i_ready !== 1'b1)
            $display("FAIL starve_instr_grant: got addr=%h ir=%b exp 400/1", a, bus.i_ready); else passed++;
        mem_serve(0, 32'h0, ok, we, a, wd, s);
        total++; if (!ok || a !== 32'h500) $display("FAIL starve_cleared: got addr=%h exp 500", a); else passed++;
        bus.i_req = 0; bus.d_req = 0;
        tick();
    endtask

    task automatic test_flush();
        bit ok; logic we; logic [31:0] a, wd; logic [3:0] s;
        int seen = 0;
        bus.i_req = 1; bus.i_addr = 32'h600;
        tick();
        total++; if (bus.m_req !== 1'b1) $display("FAIL flush_busy_mreq: got %b exp 1", bus.m_req); else passed++;
        bus.i_flush = 1;
        tick();
        bus.i_flush = 0; bus.i_req = 0;
        if (bus.i_ready === 1'b1) seen++;
        tick(); if (bus.i_ready === 1'b1) seen++;
        tick(); if (bus.i_ready === 1'b1) seen++;
        bus.m_ready = 1; bus.m_rdata = 32'h77;
        tick();
        bus.m_ready = 0;
        if (bus.i_ready === 1'b1) seen++;
        total++; if (bus.m_req !== 1'b0 || dbg_state !== 2'd2)
            $display("FAIL flush_complete: got req=%b state=%0d exp 0/2", bus.m_req, dbg_state); else passed++;
        tick(); if (bus.i_ready === 1'b1) seen++;
        total++; if (seen !== 0) $display("FAIL flush_busy_no_ready: got %0d pulses exp 0", seen); else passed++;
        // Flush coincident with the grant cycle.
        bus.i_req = 1; bus.i_addr = 32'h610; bus.i_flush = 1;
        tick();
        bus.i_flush = 0;
        mem_serve(0, 32'h99, ok, we, a, wd, s);
        total++; if (!ok || bus.i_ready !== 1'b0) $display("FAIL flush_grant_no_ready: got ok=%b ir=%b exp 1/0", ok, bus.i_ready); else passed++;
        tick();
        // Flush during the RESP cycle itself.
        bus.i_addr = 32'h620;
        mem_serve(0, 32'h55, ok, we, a, wd, s);
        total++; if (!ok || bus.i_ready !== 1'b1) $display("FAIL flush_resp_pre: got ok=%b ir=%b exp 1/1", ok, bus.i_ready); else passed++;
        bus.i_flush = 1;
        #1;
        total++; if (bus.i_ready !== 1'b0) $display("FAIL flush_resp_suppress: got %b exp 0", bus.i_ready); else passed++;
        bus.i_req = 0;
        tick();
        bus.i_flush = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h700;
        mem_serve(0, 32'hCAFEF00D, ok, we, a, wd, s);
        total++; if (!ok || bus.d_ready !== 1'b1 || bus.d_rdata !== 32'hCAFEF00D || a !== 32'h700)
            $display("FAIL flush_next_load: got ok=%b dr=%b rdata=%h addr=%h exp 1/1/cafef00d/700", ok, bus.d_ready, bus.d_rdata, a); else passed++;
        bus.d_req = 0;
        tick();
    endtask

    task automatic test_drop_req();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'hA00;
        tick();
        bus.d_req = 0;
        tick();
        bus.m_ready = 1; bus.m_rdata = 32'h0BADF00D;
        tick();
        bus.m_ready = 0;
        total++; if (bus.d_ready !== 1'b1 || bus.d_rdata !== 32'h0BADF00D)
            $display("FAIL drop_req_ready: got dr=%b rdata=%h exp 1/0badf00d", bus.d_ready, bus.d_rdata); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok; logic we; logic [31:0] a, wd; logic [3:0] s;
        int seen = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800;
        tick();
        rst_n = 0;
        #1;
        total++; if (bus.m_req !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL rst_mid_async: got req=%b state=%0d exp 0/0", bus.m_req, dbg_state); else passed++;
        bus.d_req = 0;
        bus.m_ready = 1; bus.m_rdata = 32'h1111;
        tick(); if (bus.d_ready === 1'b1) seen++;
        bus.m_ready = 0;
        rst_n = 1;
        tick(); if (bus.d_ready === 1'b1) seen++;
        // Stray m_ready while idle must be ignored.
        bus.m_ready = 1;
        tick(); if (bus.d_ready === 1'b1 || bus.i_ready === 1'b1) seen++;
        bus.m_ready = 0;
        tick(); if (bus.d_ready === 1'b1 || bus.i_ready === 1'b1) seen++;
        total++; if (seen !== 0 || dbg_state !== 2'd0)
            $display("FAIL rst_mid_no_ready: got pulses=%0d state=%0d exp 0/0", seen, dbg_state); else passed++;
        bus.i_req = 1; bus.i_addr = 32'h900;
        mem_serve(0, 32'h1234, ok, we, a, wd, s);
        total++; if (!ok || a !== 32'h900 || bus.i_ready !== 1'b1 || bus.i_rdata !== 32'h1234)
            $display("FAIL rst_mid_restart: got ok=%b addr=%h ir=%b rdata=%h exp 1/900/1/1234", ok, a, bus.i_ready, bus.i_rdata); else passed++;
        bus.i_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starve();
        test_flush();
        test_drop_req();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Exclusivity of the two ready pulses, sampled every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.i_ready === 1'b1 && bus.d_ready === 1'b1) begin
            total++;
            $display("FAIL ready_exclusive: got ir=1 dr=1 exp not both");
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-strobe width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, max consecutive data grants while instruction request is pending.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  instruction-fetch request; held with i_addr stable until i_ready.
REQ-007 i_addr  in  ADDR_W  fetch address.
REQ-008 i_flush  in  1  pipeline redirect; cancels delivery of an outstanding fetch response.
REQ-009 i_ready  out  1  one-cycle pulse, fetch response valid.
REQ-010 i_rdata  out  DATA_W  fetched instruction, valid while i_ready high.
REQ-011 d_req  in  1  data-access request; held with d_we/d_addr/d_wdata/d_wstrb stable until d_ready.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr, d_wdata, d_wstrb  in  ADDR_W, DATA_W, DATA_W/8  data-access address, store data, byte enables.
REQ-014 d_ready  out  1  one-cycle pulse, data access complete.
REQ-015 d_rdata  out  DATA_W  load data, valid while d_ready high on loads; don't-care on stores.
REQ-016 m_req, m_we, m_addr, m_wdata, m_wstrb  out  1, 1, ADDR_W, DATA_W, DATA_W/8  shared memory command, all registered.
REQ-017 m_ready  in  1  memory completion, one-cycle pulse while m_req high.
REQ-018 m_rdata  in  DATA_W  memory read data, valid with m_ready.

Function
REQ-019 States IDLE, BUSY, RESP; one memory transaction outstanding at most.
REQ-020 IDLE: if any request high, grant one, latch its command onto m_* and set m_req=1 next cycle, go BUSY; else stay IDLE.
REQ-021 Grant priority: data over instruction, unless starve counter == STARVE_MAX and i_req high, then instruction.
REQ-022 Starve counter: +1 on each data grant while i_req high; cleared on instruction grant or whenever i_req low in IDLE; saturates at STARVE_MAX.
REQ-023 Instruction grant drives m_we=0, m_wstrb=0, m_wdata=0.
REQ-024 BUSY: hold m_* stable; on m_ready=1 capture m_rdata into granted port's rdata, drop m_req next cycle, go RESP.
REQ-025 RESP: pulse granted port's ready for exactly one cycle, go IDLE; no grant is issued in RESP.
REQ-026 Minimum latency: req high in IDLE cycle 0 -> m_req cycle 1 -> m_ready cycle 1 -> ready pulse cycle 2 -> next grant earliest cycle 3.
REQ-027 i_flush high in any cycle while instruction grant is in BUSY or IDLE-to-BUSY transition sets a drop flag; memory transaction still completes; RESP then suppresses i_ready.
REQ-028 i_flush in RESP cycle suppresses that cycle's i_ready; i_flush has no effect on data grants; drop flag cleared on entering IDLE.
REQ-029 m_ready while not BUSY is ignored.
REQ-030 Requester dropping req before its ready: transaction still completes, ready still pulses (instruction side subject to flush).
REQ-031 i_ready and d_ready never high in the same cycle.

Reset
REQ-032 reset low immediately forces: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_wstrb=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, starve counter 0, drop flag 0.
REQ-033 Reset mid-transaction abandons it with no ready pulse; after release arbitration restarts from IDLE.

Verification
REQ-034 i_req only, i_addr=0x100, m_ready 1 cycle after m_req, m_rdata=0x00000013 -> m_addr=0x100, m_we=0, i_ready one cycle with i_rdata=0x00000013, latency 3 cycles req-to-ready.
REQ-035 i_req and d_req (store, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0xF) same cycle -> data granted first (m_we=1, m_addr=0x200), d_ready pulses, then instruction granted.
REQ-036 d_req held continuously, i_req pending, STARVE_MAX=4 -> exactly 4 data grants, then instruction grant, counter cleared.
REQ-037 Fetch outstanding, i_flush pulsed during BUSY, m_ready 3 cycles later -> m_req drops normally, i_ready never asserts, next request accepted.
REQ-038 reset low while BUSY with data load -> m_req=0 same cycle, d_ready never pulses; after release new i_req completes normally.
